// File: rtl/cpu_pkg.sv
// Shared definitions for the memory request path: arbiter FSM states and memory op encodings.
package cpu_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } arb_state_e;

  localparam int unsigned OpW = 2;

  localparam logic [OpW-1:0] OpNone = 2'b00;
  localparam logic [OpW-1:0] OpRead = 2'b01;

endpackage

// File: rtl/rr_picker.sv
// Combinational next-winner search: first set request at or after ptr_i, wrapping modulo NUM_REQ.
// With RR_MODE == 0 the search always starts at channel 0 (fixed priority).
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned RR_MODE = 1,
  parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [IdxW-1:0]    winner_o,
  output logic               any_o
);

  always_comb begin
    int unsigned base;
    int unsigned idx;
    logic [IdxW-1:0] idx_w;
    base     = (RR_MODE != 0) ? 32'(ptr_i) : 32'd0;
    idx      = 0;
    idx_w    = '0;
    winner_o = '0;
    any_o    = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx   = (base + k) % NUM_REQ;
      idx_w = IdxW'(idx);
      if (!any_o && req_i[idx_w]) begin
        winner_o = idx_w;
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates NUM_REQ request channels onto a single memory controller port, one transaction
// outstanding at a time, with a response/error pulse routed back to the owning channel.
module mem_req_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDRW   = 32,
  parameter int unsigned INW     = 512,
  parameter int unsigned OPW     = OpW,
  parameter int unsigned RR_MODE = 1,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*ADDRW-1:0] req_addr,
  input  logic [NUM_REQ*OPW-1:0]   req_op,
  output logic [ADDRW-1:0]         mem_address,
  output logic [OPW-1:0]           op,
  output logic                     mem_req_valid,
  input  logic                     dma_ready,
  input  logic                     rd_valid,
  input  logic [INW-1:0]           common_data_bus_in,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [INW-1:0]           rsp_data,
  output logic [NUM_REQ-1:0]       rsp_err,
  output logic                     stall
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  arb_state_e           state_q;
  logic [IdxW-1:0]      owner_q;
  logic [IdxW-1:0]      ptr_q;
  logic [CntW-1:0]      cnt_q;
  logic [ADDRW-1:0]     addr_q;
  logic [OPW-1:0]       op_q;
  logic                 mrv_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [NUM_REQ-1:0]   rsp_err_q;
  logic [INW-1:0]       rsp_data_q;

  logic [NUM_REQ-1:0][ADDRW-1:0] addr_arr;
  logic [NUM_REQ-1:0][OPW-1:0]   op_arr;
  logic [IdxW-1:0]               win;
  logic                          any_req;
  logic [IdxW-1:0]               next_ptr;
  logic [NUM_REQ-1:0]            owner_oh;

  assign addr_arr = req_addr;
  assign op_arr   = req_op;
  assign next_ptr = (win == IdxW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  assign owner_oh = NUM_REQ'(1) << owner_q;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .RR_MODE (RR_MODE),
    .IdxW    (IdxW)
  ) u_picker (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .winner_o (win),
    .any_o    (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      op_q        <= '0;
      mrv_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            owner_q <= win;
            addr_q  <= addr_arr[win];
            op_q    <= op_arr[win];
            mrv_q   <= 1'b1;
            state_q <= StIssue;
            if (RR_MODE != 0) ptr_q <= next_ptr;
          end
        end
        StIssue: begin
          if (dma_ready) begin
            addr_q  <= '0;
            op_q    <= '0;
            mrv_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          // rd_valid takes precedence over a timeout expiring in the same cycle
          if (rd_valid) begin
            rsp_data_q  <= common_data_bus_in;
            rsp_valid_q <= owner_oh;
            state_q     <= StIdle;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            rsp_err_q <= owner_oh;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_address   = addr_q;
  assign op            = op_q;
  assign mem_req_valid = mrv_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_data      = rsp_data_q;
  assign stall         = |(req_valid & ~(rsp_valid_q | rsp_err_q));

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a 2-channel instance checked every cycle against a
// transaction-level model, plus 4-channel round-robin and fixed-priority instances.
module tb_mem_req_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: 2 channels, round-robin, TIMEOUT = 8
  logic [1:0]   a_req = '0;
  logic [63:0]  a_addr_in = '0;
  logic [3:0]   a_op_in = 4'b0101;
  logic [31:0]  a_mem_addr;
  logic [1:0]   a_op;
  logic         a_mrv;
  logic         a_dma = 1'b0;
  logic         a_rd = 1'b0;
  logic [511:0] a_bus = '0;
  logic [1:0]   a_rsp_v, a_rsp_e;
  logic [511:0] a_rsp_data;
  logic         a_stall;

  mem_req_arbiter #(
    .NUM_REQ(2), .ADDRW(32), .INW(512), .OPW(2), .RR_MODE(1), .TIMEOUT(8)
  ) u_a (
    .clk(clk), .rst(rst), .req_valid(a_req), .req_addr(a_addr_in), .req_op(a_op_in),
    .mem_address(a_mem_addr), .op(a_op), .mem_req_valid(a_mrv), .dma_ready(a_dma),
    .rd_valid(a_rd), .common_data_bus_in(a_bus), .rsp_valid(a_rsp_v), .rsp_data(a_rsp_data),
    .rsp_err(a_rsp_e), .stall(a_stall)
  );

  // Instances B (round-robin) and C (fixed priority): 4 channels, shared stimulus
  logic [3:0]   b_req = '0;
  logic [127:0] b_addr_in = {32'h400, 32'h300, 32'h200, 32'h100};
  logic [7:0]   b_op_in = 8'h55;
  logic         b_dma = 1'b0;
  logic         b_rd = 1'b0;
  logic [31:0]  b_bus = 32'h0;
  logic [31:0]  rr_addr, fp_addr, rr_data, fp_data;
  logic [1:0]   rr_op, fp_op;
  logic         rr_mrv, fp_mrv, rr_stall, fp_stall;
  logic [3:0]   rr_rv, rr_re, fp_rv, fp_re;

  mem_req_arbiter #(
    .NUM_REQ(4), .ADDRW(32), .INW(32), .OPW(2), .RR_MODE(1), .TIMEOUT(1023)
  ) u_rr (
    .clk(clk), .rst(rst), .req_valid(b_req), .req_addr(b_addr_in), .req_op(b_op_in),
    .mem_address(rr_addr), .op(rr_op), .mem_req_valid(rr_mrv), .dma_ready(b_dma),
    .rd_valid(b_rd), .common_data_bus_in(b_bus), .rsp_valid(rr_rv), .rsp_data(rr_data),
    .rsp_err(rr_re), .stall(rr_stall)
  );

  mem_req_arbiter #(
    .NUM_REQ(4), .ADDRW(32), .INW(32), .OPW(2), .RR_MODE(0), .TIMEOUT(1023)
  ) u_fp (
    .clk(clk), .rst(rst), .req_valid(b_req), .req_addr(b_addr_in), .req_op(b_op_in),
    .mem_address(fp_addr), .op(fp_op), .mem_req_valid(fp_mrv), .dma_ready(b_dma),
    .rd_valid(b_rd), .common_data_bus_in(b_bus), .rsp_valid(fp_rv), .rsp_data(fp_data),
    .rsp_err(fp_re), .stall(fp_stall)
  );

  // Transaction-level model of instance A: phase 0 idle, 1 issuing, 2 awaiting data
  int           m_phase = 0;
  int           m_owner = 0;
  int           m_ptr = 0;
  int           m_waited = 0;
  logic [31:0]  m_addr = '0;
  logic [1:0]   m_op = '0;
  logic [511:0] m_data = '0;
  logic [1:0]   m_rv = '0;
  logic [1:0]   m_re = '0;

  always @(posedge clk) begin
    m_rv = '0;
    m_re = '0;
    if (rst) begin
      m_phase = 0;
      m_ptr   = 0;
      m_data  = '0;
    end else if (m_phase == 0) begin
      if (a_req != 2'b00) begin
        m_owner = a_req[m_ptr] ? m_ptr : (m_ptr + 1) % 2;
        m_addr  = a_addr_in[m_owner*32 +: 32];
        m_op    = a_op_in[m_owner*2 +: 2];
        m_ptr   = (m_owner + 1) % 2;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (a_dma) begin
        m_phase  = 2;
        m_waited = 0;
      end
    end else begin
      m_waited++;
      if (a_rd) begin
        m_data  = a_bus;
        m_rv    = 2'b01 << m_owner;
        m_phase = 0;
      end else if (m_waited == 8) begin
        m_re    = 2'b01 << m_owner;
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req_valid", a_mrv, m_phase == 1);
      chk("mem_address", a_mem_addr, (m_phase == 1) ? m_addr : 32'h0);
      chk("op", a_op, (m_phase == 1) ? m_op : 2'b00);
      chk("rsp_valid", a_rsp_v, m_rv);
      chk("rsp_err", a_rsp_e, m_re);
      chk("rsp_data", a_rsp_data, m_data);
      chk("stall", a_stall, |(a_req & ~(m_rv | m_re)));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_g[5];
    int fp_g[5];
    int ng;
    bit seen;
    int mrv_cnt;
    int err_at;

    for (int i = 0; i < 5; i++) begin
      rr_g[i] = -1;
      fp_g[i] = -1;
    end
    @(posedge clk);
    chk_en = 1'b1;
    #1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_mrv", a_mrv, 1'b0);
    chk("reset_addr", a_mem_addr, 32'h0);
    chk("reset_rsp_data", a_rsp_data, 512'h0);
    chk("reset_rr_mrv", rr_mrv, 1'b0);

    // Round-robin vs fixed priority with all four channels held
    b_req = 4'hF;
    b_dma = 1'b1;
    ng = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 40 && ng < 5; cyc++) begin
      tick();
      b_rd = seen;
      @(negedge clk);
      seen = rr_mrv;
      if (rr_mrv) begin
        rr_g[ng] = int'(rr_addr / 256) - 1;
        fp_g[ng] = int'(fp_addr / 256) - 1;
        ng++;
      end
    end
    tick();
    b_rd  = seen;
    b_req = 4'h0;
    tick();
    b_rd = 1'b0;
    repeat (2) tick();
    chk("grant_count", ng, 5);
    chk("rr_grant0", rr_g[0], 0);
    chk("rr_grant1", rr_g[1], 1);
    chk("rr_grant2", rr_g[2], 2);
    chk("rr_grant3", rr_g[3], 3);
    chk("rr_grant4", rr_g[4], 0);
    for (int i = 0; i < 5; i++) chk($sformatf("fp_grant%0d", i), fp_g[i], 0);

    // Single read on channel 0
    a_addr_in = {32'h80, 32'h40};
    a_dma = 1'b1;
    a_req = 2'b01;
    @(negedge clk);
    chk("single_stall_req", a_stall, 1'b1);
    tick();
    @(negedge clk);
    chk("single_issue_mrv", a_mrv, 1'b1);
    chk("single_issue_addr", a_mem_addr, 32'h40);
    chk("single_issue_op", a_op, 2'b01);
    tick();
    @(negedge clk);
    chk("single_wait_mrv", a_mrv, 1'b0);
    tick();
    a_rd  = 1'b1;
    a_bus = 512'hAB;
    @(negedge clk);
    chk("single_stall_wait", a_stall, 1'b1);
    tick();
    a_rd  = 1'b0;
    a_req = 2'b00;
    @(negedge clk);
    chk("single_rsp_valid", a_rsp_v, 2'b01);
    chk("single_rsp_data", a_rsp_data, 512'hAB);
    chk("single_stall_fall", a_stall, 1'b0);
    repeat (2) tick();

    // Backpressure on channel 1: dma_ready low for 5 issue cycles
    a_dma = 1'b0;
    a_req = 2'b10;
    mrv_cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) a_dma = 1'b1;
      if (i == 7) begin
        a_rd  = 1'b1;
        a_bus = 512'h1234;
      end
      @(negedge clk);
      if (a_mrv) begin
        mrv_cnt++;
        chk("bp_addr_stable", a_mem_addr, 32'h80);
      end
    end
    tick();
    a_rd  = 1'b0;
    a_req = 2'b00;
    @(negedge clk);
    chk("bp_issue_cycles", mrv_cnt, 6);
    chk("bp_rsp_valid", a_rsp_v, 2'b10);
    chk("bp_rsp_data", a_rsp_data, 512'h1234);
    repeat (2) tick();

    // Timeout on channel 0; requester drops mid-transaction, response still routed
    a_req = 2'b01;
    err_at = -1;
    for (int i = 1; i <= 20 && err_at < 0; i++) begin
      tick();
      if (i == 1) a_req = 2'b00;
      @(negedge clk);
      if (a_rsp_e != 2'b00) begin
        err_at = i;
        chk("timeout_err_owner", a_rsp_e, 2'b01);
      end
    end
    chk("timeout_latency", err_at, 10);
    repeat (2) tick();
    a_rd  = 1'b1;
    a_bus = 512'hDEAD;
    tick();
    a_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_rd_no_rsp", a_rsp_v, 2'b00);
      tick();
    end

    // Reset during WAIT, then a stray rd_valid
    a_req = 2'b01;
    tick();
    a_req = 2'b00;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_rd  = 1'b1;
    a_bus = 512'hCD;
    tick();
    a_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", a_rsp_v, 2'b00);
      chk("rst_no_err", a_rsp_e, 2'b00);
      tick();
    end
    a_req = 2'b11;
    tick();
    @(negedge clk);
    chk("rst_ptr_grant", a_mem_addr, 32'h40);
    a_req = 2'b00;
    tick();
    a_rd  = 1'b1;
    a_bus = 512'h77;
    tick();
    a_rd = 1'b0;
    @(negedge clk);
    chk("rst_after_rsp", a_rsp_v, 2'b01);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesting channels, range 2..8; channel 0 is instruction fetch.
REQ-002 Parameter ADDRW, default 32: request address width.
REQ-003 Parameter INW, default 512: response data width, equal to the common data bus width.
REQ-004 Parameter OPW, default 2: memory op code width.
REQ-005 Parameter RR_MODE, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, lowest index wins.
REQ-006 Parameter TIMEOUT, default 1023: maximum number of WAIT cycles before a transaction is aborted; must be at least 1.
REQ-007 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-008 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 Port req_valid, input, NUM_REQ bits: per-channel request, held high until that channel's rsp_valid or rsp_err.
REQ-010 Port req_addr, input, NUM_REQ*ADDRW bits: packed per-channel addresses; channel i occupies bits [i*ADDRW +: ADDRW].
REQ-011 Port req_op, input, NUM_REQ*OPW bits: packed per-channel op codes.
REQ-012 Port mem_address, output, ADDRW bits: address presented to the memory controller.
REQ-013 Port op, output, OPW bits: op code presented to the memory controller.
REQ-014 Port mem_req_valid, output, 1 bit: request strobe to the memory controller.
REQ-015 Port dma_ready, input, 1 bit: the memory controller accepts the request in the cycle where dma_ready and mem_req_valid are both high.
REQ-016 Port rd_valid, input, 1 bit: response data valid on common_data_bus_in.
REQ-017 Port common_data_bus_in, input, INW bits: response data.
REQ-018 Port rsp_valid, output, NUM_REQ bits: one-hot, one-cycle pulse to the channel that owns the transaction.
REQ-019 Port rsp_data, output, INW bits: registered response data, shared by all channels.
REQ-020 Port rsp_err, output, NUM_REQ bits: one-hot, one-cycle pulse to the owning channel on timeout.
REQ-021 Port stall, output, 1 bit: high while any req_valid bit is set and that channel has not yet received its response or error pulse.

Function
REQ-022 The arbiter SHALL be a three-state FSM with states IDLE, ISSUE and WAIT, and SHALL allow at most one outstanding transaction.
REQ-023 In IDLE with any req_valid bit set, the FSM SHALL choose a winner, latch its index, address and op, and move to ISSUE on the next cycle.
- Request latency: req_valid rising in cycle N gives mem_req_valid high in cycle N+1.
REQ-024 In round-robin mode, the search SHALL start at rr_ptr and wrap modulo NUM_REQ; after each grant, rr_ptr SHALL become (winner+1) mod NUM_REQ.
REQ-025 In fixed-priority mode, rr_ptr SHALL stay at 0 and is not used.
REQ-026 In ISSUE, mem_req_valid SHALL be high and mem_address/op SHALL hold the latched values, stable until dma_ready is sampled high; the FSM then moves to WAIT.
REQ-027 In WAIT, on rd_valid the arbiter SHALL capture common_data_bus_in into rsp_data, pulse rsp_valid[owner] in the following cycle, and return to IDLE.
REQ-028 Any rd_valid seen in IDLE or ISSUE SHALL be ignored.
REQ-029 A timeout counter SHALL clear on entry to WAIT and count each WAIT cycle.
- If the counter reaches TIMEOUT without rd_valid, the arbiter SHALL pulse rsp_err[owner] and return to IDLE.
- If rd_valid arrives in the same cycle as expiry, rd_valid wins and no error is raised.
REQ-030 If the owner deasserts req_valid mid-transaction, the transaction SHALL still complete and the response pulse SHALL still be issued.
REQ-031 There SHALL be at least one IDLE cycle between back-to-back transactions.
- Peak throughput: one transaction per 3 + memory-latency cycles.
REQ-032 Outside ISSUE, mem_req_valid SHALL be low and mem_address/op SHALL be driven to 0.
REQ-033 rsp_valid and rsp_err SHALL never be high in the same cycle, and each SHALL be one-hot or zero.

Reset
REQ-034 While rst is high at a rising clock edge, the arbiter SHALL:
- set the FSM to IDLE and rr_ptr to 0;
- clear the timeout counter;
- clear mem_req_valid, mem_address, op, rsp_valid, rsp_err and rsp_data to 0.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction with no response or error pulse; any later rd_valid for it is dropped.

Structure
REQ-036 The FSM state enum, the OPW default and the op encodings (00 none, 01 read) SHALL live in a shared package, cpu_pkg.
REQ-037 The next-winner search SHALL be a combinational sub-module, rr_picker, parameterised by NUM_REQ and RR_MODE.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- Single read: req_valid=01, addr0=0x40, dma_ready=1, rd_valid two cycles later with data 0xAB -> mem_address=0x40 with op=01 for one cycle; rsp_valid=01 with rsp_data=0xAB; stall falls the same cycle.
- Round-robin: NUM_REQ=4, req_valid=1111 held -> grants in order 0,1,2,3,0.
- Fixed priority: same stimulus with RR_MODE=0 -> channel 0 granted every time.
- Backpressure: dma_ready held low for 5 cycles -> mem_req_valid high with address stable for 6 cycles, then WAIT.
- Timeout: TIMEOUT=8 with no rd_valid -> rsp_err pulses to the owner 8 cycles after entering WAIT; a later rd_valid produces no rsp_valid.
- Reset during WAIT: rst pulse, then rd_valid -> no response pulses, FSM in IDLE, rr_ptr=0.
